piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter. Serializes one WIDTH-bit word per transfer onto a single-bit line, MSB first.
- Transmit end of the team's serial shift-chain link. It drives the line that a shift-register or deserializer chain samples.
- Ready/valid load handshake, so upstream logic can supply words back-to-back with no idle gap on the line.

---
 rtl/piso_tx.sv | 109 ++++++++++
 tb/tb_piso_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// Serializes one WIDTH-bit word per frame onto a single line, MSB first,
// behind a ready/valid load handshake that allows back-to-back frames with
// no idle cycle on the line.
// Optional feature: define PISO_PARITY_EN to append the even-parity bit of
// each word as an extra serial bit, making each frame WIDTH+1 cycles long.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  // Counter value of the final bit of a frame (data MSB..LSB, then parity).
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

`ifdef PISO_PARITY_EN
  // Counter value of the data LSB; the next edge moves parity into the MSB.
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  logic parity_q, parity_d;
`endif

  // The line is the register MSB, so it never sees the inputs combinationally.
  // Once a frame has shifted out the register is all zeros and out rests at 0.
  assign out        = shift_q[WIDTH-1];
  assign out_valid  = (state_q == SHIFT);
  assign done       = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || done;
  assign accept     = load_valid && load_ready;

  // Next-state logic: shift while in a frame, reload on an accepted handshake.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == SHIFT) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q + CW'(1);
`ifdef PISO_PARITY_EN
      // Lower bits are already zero here, so the parity bit lands alone in the MSB.
      if (cnt_q == DATA_LAST) shift_d[WIDTH-1] = parity_q;
`endif
      if (done) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
    // A handshake in the last-bit cycle overrides the return to IDLE, which is
    // what keeps out_valid high across consecutive frames.
    if (accept) begin
      state_d  = SHIFT;
      shift_d  = data_in;
      cnt_d    = '0;
`ifdef PISO_PARITY_EN
      parity_d = ^data_in;
`endif
    end
  end

  // State registers with asynchronous active-low reset; reset aborts any frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (WIDTH = 8). Honours PISO_PARITY_EN.
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         out;
  logic         out_valid;
  logic         done;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the bits still to appear on the line, oldest first.
  // The head is the bit on the line in the current cycle.
  bit exp_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e_out;
    logic         e_ov;
    logic         e_done;
    logic         e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_out, input logic e_ov,
                            input logic e_done, input logic e_rdy);
    check({tag, ".out"},        out,        e_out);
    check({tag, ".out_valid"},  out_valid,  e_ov);
    check({tag, ".done"},       done,       e_done);
    check({tag, ".load_ready"}, load_ready, e_rdy);
  endtask

  task automatic model_push(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // One clock cycle: drive inputs, advance DUT and model, compare outputs.
  task automatic step(input logic v, input logic [W-1:0] d, input string tag);
    bit acc;
    load_valid = v;
    data_in    = d;
    acc = v && (exp_q.size() <= 1);
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) model_push(d);
    #1;
    check_outs(tag, (exp_q.size() > 0) ? exp_q[0] : 1'b0, exp_q.size() > 0,
               exp_q.size() == 1, exp_q.size() <= 1);
  endtask

  task automatic add_vec(input logic v, input logic [W-1:0] d, input logic e_out,
                         input logic e_ov, input logic e_done, input logic e_rdy);
    vec_t r;
    r.v = v; r.d = d; r.e_out = e_out; r.e_ov = e_ov; r.e_done = e_done; r.e_rdy = e_rdy;
    vecs.push_back(r);
  endtask

  initial begin
    logic [W-1:0] got;

    // ---- Reset held with load_valid asserted ----
    reset      = 1'b0;
    load_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (4) begin
      @(posedge clk); #1;
      check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    exp_q.delete();
    step(1'b1, 8'hFF, "post_reset");
    check("post_reset.first_bit", out, 1'b1);
    repeat (FRAME) step(1'b0, 8'h00, "post_reset_drain");

    // ---- Table: single A5 frame with busy-ignored 3C offers ----
    // Row k drives the inputs before edge N+k; expectations are for cycle N+k+1.
    add_vec(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PISO_PARITY_EN
    add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);  // parity of A5 is 0
    add_vec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // 07: bits 0,0,0,0,0,1,1,1 then parity 1
    add_vec(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    foreach (vecs[k]) begin
      load_valid = vecs[k].v;
      data_in    = vecs[k].d;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", k), vecs[k].e_out, vecs[k].e_ov,
                 vecs[k].e_done, vecs[k].e_rdy);
    end

    // ---- Back-to-back FF then 00 with load_valid held ----
    load_valid = 1'b1;
    data_in    = 8'hFF;
    @(posedge clk); #1;
    data_in = 8'h00;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      check($sformatf("b2b.out_valid[%0d]", i), out_valid, 1'b1);
      check($sformatf("b2b.done[%0d]", i), done, (i == FRAME) || (i == 2 * FRAME));
      check($sformatf("b2b.out[%0d]", i), out, i <= W);
      if (i >= FRAME + 1) load_valid = 1'b0;
      @(posedge clk); #1;
    end
    check_outs("b2b_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // ---- Reset mid-word, then a clean 81 frame ----
    load_valid = 1'b1;
    data_in    = 8'hA5;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("rst_mid.bit1", out, 1'b1);
    @(posedge clk); #1;
    check("rst_mid.bit2", out, 1'b0);
    @(posedge clk); #1;
    check("rst_mid.bit3", out, 1'b1);
    #2 reset = 1'b0;
    #1 check_outs("rst_mid_async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_outs("rst_mid_held", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    step(1'b1, 8'h81, "rst_mid_81");
    got = {7'b0, out};
    for (int i = 1; i < W; i++) begin
      step(1'b0, 8'h00, "rst_mid_81");
      got = {got[W-2:0], out};
    end
    check("rst_mid.word81", got, 8'h81);
    repeat (FRAME) step(1'b0, 8'h00, "rst_mid_drain");

    // ---- Randomized traffic against the reference model ----
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, W'($urandom), $sformatf("rand%0d", n));
    end
    repeat (FRAME + 1) step(1'b0, 8'h00, "rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
